// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_e;

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0] ROW_PAT [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  // Index of the lowest closed (low) column; only meaningful when one is low.
  function automatic logic [1:0] first_low(input logic [3:0] col);
    if (!col[0])      first_low = 2'd0;
    else if (!col[1]) first_low = 2'd1;
    else if (!col[2]) first_low = 2'd2;
    else              first_low = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate press/release debouncer: one key_valid pulse per accepted press,
// key_held from acceptance until a debounced release.
import keypad_pkg::*;

module keypad_debounce #(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             hit,
  input  logic [KEY_W-1:0] code,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  kp_state_e        state, state_n;
  logic [CW-1:0]    cnt, cnt_n, rel_cnt, rel_n;
  logic [KEY_W-1:0] cand, cand_n, code_n;
  logic             valid_n, held_n;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rel_cnt   <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rel_cnt   <= rel_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  // Next state; everything moves only on a frame boundary, key_valid self-clears.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rel_n   = rel_cnt;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (frame_tick) begin
      unique case (state)
        IDLE: if (hit) begin
          cand_n = code;
          if (LIMIT == ONE) begin
            state_n = PRESSED;
            code_n  = code;
            valid_n = 1'b1;
            held_n  = 1'b1;
            rel_n   = '0;
          end else begin
            state_n = DEBOUNCE;
            cnt_n   = ONE;
          end
        end
        DEBOUNCE: begin
          if (!hit) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (code != cand) begin
            cand_n = code;
            cnt_n  = ONE;
          end else if (cnt + ONE == LIMIT) begin
            state_n = PRESSED;
            cnt_n   = '0;
            code_n  = cand;
            valid_n = 1'b1;
            held_n  = 1'b1;
            rel_n   = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        PRESSED: begin
          // Any key keeps the press alive; new keys are not reported.
          if (hit) rel_n = '0;
          else if (LIMIT == ONE) begin
            state_n = IDLE;
            held_n  = 1'b0;
          end else begin
            state_n = RELEASE;
            rel_n   = ONE;
          end
        end
        RELEASE: begin
          if (hit) begin
            state_n = PRESSED;
            rel_n   = '0;
          end else if (rel_cnt + ONE == LIMIT) begin
            state_n = IDLE;
            held_n  = 1'b0;
            rel_n   = '0;
          end else begin
            rel_n = rel_cnt + ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanned 4x4 keypad reader: row drive, column sync, per-frame priority
// encode, then frame-rate debounce.
import keypad_pkg::*;

module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_col,
  output logic [3:0]       key_row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] dwell;
  logic [1:0]       row_idx;
  logic [3:0]       col_s1, col_s2;
  logic             scr_hit;
  logic [KEY_W-1:0] scr_code;
  logic             sample, row_hit, frame_tick, frame_hit;
  logic [KEY_W-1:0] row_code, frame_code;

  assign key_row    = ROW_PAT[row_idx];
  assign sample     = (dwell == DIV_W'(SCAN_DIV - 1));
  assign row_hit    = ~&col_s2;
  assign row_code   = {row_idx, first_low(col_s2)};
  assign frame_tick = sample && (row_idx == 2'd3);
  // Rows are sampled in order, so an earlier row's hit always has the lower code.
  assign frame_hit  = scr_hit | row_hit;
  assign frame_code = scr_hit ? scr_code : row_code;

  // Two-flop synchroniser on the column lines; idle level is all-open.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= key_col;
      col_s2 <= col_s1;
    end
  end

  // Dwell counter and row index; free-running in every debounce state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell   <= '0;
      row_idx <= '0;
    end else if (sample) begin
      dwell   <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      dwell <= dwell + DIV_W'(1);
    end
  end

  // Frame scratch: first hit of rows 0..2; cleared when the frame result is consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scr_hit  <= 1'b0;
      scr_code <= '0;
    end else if (sample) begin
      if (frame_tick) begin
        scr_hit  <= 1'b0;
        scr_code <= '0;
      end else if (!scr_hit && row_hit) begin
        scr_hit  <= 1'b1;
        scr_code <= row_code;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .hit       (frame_hit),
    .code      (frame_code),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

endmodule
